// File: rtl/lc3b_write_buffer.sv
// ---------------------------------------------------------------------------
// lc3b_write_buffer
//
// Purpose:
//   Small circular FIFO of evicted dirty cache blocks that sits between the
//   cache and physical memory. Blocks are drained one at a time to pmem in
//   arrival order. A push whose block is already buffered overwrites that
//   entry in place (coalescing), except for the head entry while its write
//   is in flight. The cache can snoop the buffer on a read miss through the
//   combinational lookup port, which returns the youngest matching copy.
//
// Ports:
//   clk          - single clock, all state rises on clk
//   reset        - synchronous, active-high; aborts any drain in progress
//   push_valid   - cache offers an evicted dirty block
//   push_addr    - block byte address (offset bits are don't-care)
//   push_data    - block data
//   push_ready   - buffer accepts the offered block this cycle
//   lookup_addr  - read-miss address to snoop
//   lookup_hit   - a valid buffered block matches lookup_addr
//   lookup_data  - data of the youngest matching block (0 on miss)
//   pmem_address - drain address, offset bits zero (0 when idle)
//   pmem_wdata   - drain data (0 when idle)
//   pmem_write   - physical memory write request
//   pmem_resp    - physical memory completed the write
//   empty        - no valid entries
//   count        - number of valid entries
// ---------------------------------------------------------------------------
module lc3b_write_buffer #(
   parameter int DEPTH    = 4,
   parameter int BLOCK_W  = 128,
   parameter int ADDR_W   = 16,
   parameter int OFFSET_W = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_valid,
   input  logic [ADDR_W-1:0]            push_addr,
   input  logic [BLOCK_W-1:0]           push_data,
   output logic                         push_ready,
   input  logic [ADDR_W-1:0]            lookup_addr,
   output logic                         lookup_hit,
   output logic [BLOCK_W-1:0]           lookup_data,
   output logic [ADDR_W-1:0]            pmem_address,
   output logic [BLOCK_W-1:0]           pmem_wdata,
   output logic                         pmem_write,
   input  logic                         pmem_resp,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int TAG_W = ADDR_W - OFFSET_W;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } drain_state_t;

   drain_state_t state_q;
   drain_state_t state_next;

   // Entry storage: valid bits are reset, tag/data are qualified by valid
   logic [DEPTH-1:0]   valid_q;
   logic [TAG_W-1:0]   tag_q  [DEPTH];
   logic [BLOCK_W-1:0] data_q [DEPTH];

   logic [PTR_W-1:0]   head_q;
   logic [PTR_W-1:0]   tail_q;
   logic [CNT_W-1:0]   count_q;

   logic [TAG_W-1:0]   push_tag;
   logic [TAG_W-1:0]   lookup_tag;
   logic               full;
   logic               coal_hit;
   logic [PTR_W-1:0]   coal_idx;
   logic               push_fire;
   logic               alloc;
   logic               coal_write;
   logic               pop;

   assign push_tag   = push_addr[ADDR_W-1:OFFSET_W];
   assign lookup_tag = lookup_addr[ADDR_W-1:OFFSET_W];

   // Full comes straight from the registered count, so a pop on the same
   // edge never makes room for a fresh allocation.
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   // Coalesce search: any valid entry with the same tag, except the head
   // while its write is in flight (its data must stay stable for pmem).
   // Coalescing keeps at most one eligible copy per tag, so priority among
   // multiple hits is irrelevant.
   always_comb begin
      coal_hit = 1'b0;
      coal_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (tag_q[i] == push_tag) &&
             !((state_q == DRAIN) && (PTR_W'(i) == head_q))) begin
            coal_hit = 1'b1;
            coal_idx = PTR_W'(i);
         end
      end
   end

   assign push_ready = !full || coal_hit;
   assign push_fire  = push_valid && push_ready;
   assign alloc      = push_fire && !coal_hit;
   assign coal_write = push_fire && coal_hit;

   // Snoop: walk from the oldest entry to the youngest so that the last
   // match seen wins. The only duplicate case is the draining head plus a
   // newer copy, and the newer copy is the one the cache must see.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx         = '0;
      lookup_hit  = 1'b0;
      lookup_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PTR_W'(k);
         if (valid_q[idx] && (tag_q[idx] == lookup_tag)) begin
            lookup_hit  = 1'b1;
            lookup_data = data_q[idx];
         end
      end
   end

   // Drain FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_next;
      end
   end

   // Drain FSM next state and pmem outputs. IDLE always lasts at least one
   // cycle between writes; pmem_resp is only meaningful in DRAIN.
   always_comb begin
      state_next   = state_q;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      pop          = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            pmem_write   = 1'b1;
            pmem_address = {tag_q[head_q], {OFFSET_W{1'b0}}};
            pmem_wdata   = data_q[head_q];
            if (pmem_resp) begin
               pop        = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Pointers, valid bits and occupancy. A pop and an allocation can never
   // touch the same slot: that would need head==tail with the buffer both
   // non-empty and not full.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + PTR_W'(1);
         end
         if (alloc) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + PTR_W'(1);
         end
         case ({alloc, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Tag/data payload. Not reset since valid qualifies every read; writes
   // are still suppressed under reset so reset clearly wins over a push.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (alloc) begin
            tag_q[tail_q]  <= push_tag;
            data_q[tail_q] <= push_data;
         end else if (coal_write) begin
            data_q[coal_idx] <= push_data;
         end
      end
   end

endmodule

// File: tb/tb_lc3b_write_buffer.sv
module tb_lc3b_write_buffer;

   localparam int DEPTH    = 4;
   localparam int BLOCK_W  = 128;
   localparam int ADDR_W   = 16;
   localparam int OFFSET_W = 4;
   localparam int CNT_W    = $clog2(DEPTH+1);

   logic                clk;
   logic                reset;
   logic                push_valid;
   logic [ADDR_W-1:0]   push_addr;
   logic [BLOCK_W-1:0]  push_data;
   logic                push_ready;
   logic [ADDR_W-1:0]   lookup_addr;
   logic                lookup_hit;
   logic [BLOCK_W-1:0]  lookup_data;
   logic [ADDR_W-1:0]   pmem_address;
   logic [BLOCK_W-1:0]  pmem_wdata;
   logic                pmem_write;
   logic                pmem_resp;
   logic                empty;
   logic [CNT_W-1:0]    count;

   lc3b_write_buffer #(
      .DEPTH(DEPTH), .BLOCK_W(BLOCK_W), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)
   ) dut (
      .clk(clk), .reset(reset),
      .push_valid(push_valid), .push_addr(push_addr), .push_data(push_data),
      .push_ready(push_ready),
      .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_write(pmem_write),
      .pmem_resp(pmem_resp),
      .empty(empty), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: an ordered list of buffered blocks (oldest first) and
   // a flag saying the oldest block's write is in flight.
   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [BLOCK_W-1:0] data;
   } blk_t;

   blk_t exp_q[$];
   bit   busy;
   int   total;
   int   bad;
   int   drained;
   bit   pend_acc;
   bit   pend_coal;

   task automatic chk(input string nm, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%h want=%h at %0t", nm, act, want, $time);
      end
   endtask

   function automatic logic [ADDR_W-OFFSET_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1:OFFSET_W];
   endfunction

   function automatic logic [ADDR_W-1:0] blk_addr(input logic [ADDR_W-1:0] a);
      return {tag_of(a), {OFFSET_W{1'b0}}};
   endfunction

   // A buffered copy that is not the in-flight head can absorb the push.
   function automatic bit model_coal(input logic [ADDR_W-1:0] a);
      for (int j = 0; j < exp_q.size(); j++) begin
         if (tag_of(exp_q[j].addr) == tag_of(a) && !(busy && j == 0)) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Compare every observable output with the model, before the edge.
   task automatic checkOutput();
      bit                 want_ready;
      bit                 want_hit;
      logic [BLOCK_W-1:0] want_ldata;
      want_ready = (exp_q.size() < DEPTH) || model_coal(push_addr);
      chk("push_ready", BLOCK_W'(push_ready), BLOCK_W'(want_ready));
      chk("count", BLOCK_W'(count), BLOCK_W'(exp_q.size()));
      chk("empty", BLOCK_W'(empty), BLOCK_W'(exp_q.size() == 0));
      chk("pmem_write", BLOCK_W'(pmem_write), BLOCK_W'(busy));
      if (busy && exp_q.size() > 0) begin
         chk("pmem_address", BLOCK_W'(pmem_address), BLOCK_W'(exp_q[0].addr));
         chk("pmem_wdata", pmem_wdata, exp_q[0].data);
      end else begin
         chk("pmem_address_idle", BLOCK_W'(pmem_address), '0);
         chk("pmem_wdata_idle", pmem_wdata, '0);
      end
      want_hit   = 1'b0;
      want_ldata = '0;
      foreach (exp_q[j]) begin
         if (tag_of(exp_q[j].addr) == tag_of(lookup_addr)) begin
            want_hit   = 1'b1;
            want_ldata = exp_q[j].data;
         end
      end
      chk("lookup_hit", BLOCK_W'(lookup_hit), BLOCK_W'(want_hit));
      chk("lookup_data", lookup_data, want_ldata);
      pend_acc  = push_valid && want_ready;
      pend_coal = model_coal(push_addr);
   endtask

   // Drive one cycle of inputs, check, then advance the model across the edge.
   task automatic applyStimulus(input bit rst, input bit pv, input logic [ADDR_W-1:0] pa,
                                input logic [BLOCK_W-1:0] pd, input bit resp,
                                input logic [ADDR_W-1:0] la);
      blk_t b;
      reset       = rst;
      push_valid  = pv;
      push_addr   = pa;
      push_data   = pd;
      pmem_resp   = resp;
      lookup_addr = la;
      #2;
      checkOutput();
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
         busy = 1'b0;
      end else begin
         if (busy && resp) busy = 1'b0;
         else if (!busy && exp_q.size() > 0) busy = 1'b1;
         if (pend_acc) begin
            if (pend_coal) begin
               for (int j = exp_q.size() - 1; j >= 0; j--) begin
                  if (tag_of(exp_q[j].addr) == tag_of(pa)) begin
                     exp_q[j].data = pd;
                     break;
                  end
               end
            end else begin
               b.addr = blk_addr(pa);
               b.data = pd;
               exp_q.push_back(b);
            end
         end
      end
      #1;
   endtask

   // Monitor: each completed pmem write consumes the oldest expected block.
   always @(negedge clk) begin
      if (!reset && pmem_resp && (busy || pmem_write)) begin
         if (!busy) begin
            chk("spurious_write", BLOCK_W'(pmem_write), '0);
         end else if (exp_q.size() > 0) begin
            chk("drain_write", BLOCK_W'(pmem_write), BLOCK_W'(1'b1));
            chk("drain_addr", BLOCK_W'(pmem_address), BLOCK_W'(exp_q[0].addr));
            chk("drain_data", pmem_wdata, exp_q[0].data);
            drained++;
            void'(exp_q.pop_front());
         end
      end
   end

   function automatic logic [BLOCK_W-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [ADDR_W-1:0] rnd_addr();
      return ADDR_W'(16'h0100 + ($urandom_range(0, 5) << 4) + $urandom_range(0, 15));
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, rnd_addr());
   endtask

   task automatic drain_all();
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0 && !busy) break;
         applyStimulus(0, 0, '0, '0, 1, rnd_addr());
      end
      chk("count_after_drain", BLOCK_W'(count), '0);
   endtask

   initial begin
      logic [BLOCK_W-1:0] da;
      logic [BLOCK_W-1:0] db;
      int                 d0;
      total = 0; bad = 0; drained = 0; busy = 0;
      reset = 1; push_valid = 0; push_addr = '0; push_data = '0;
      pmem_resp = 0; lookup_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(1, 0, '0, '0, 0, '0);

      // Single drain
      da = rnd_data();
      applyStimulus(0, 1, 16'h1234, da, 0, 16'h1238);
      applyStimulus(0, 0, '0, '0, 0, 16'h1230);
      applyStimulus(0, 0, '0, '0, 1, 16'h1234);
      idle(2);

      // Fill to full with no responses, fifth push refused
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, ADDR_W'(16'h2000 + i * 16), rnd_data(), 0, 16'h2010);
      chk("count_full", BLOCK_W'(count), BLOCK_W'(DEPTH));
      applyStimulus(0, 1, 16'h2045, rnd_data(), 0, 16'h2000);
      d0 = drained;
      drain_all();
      chk("fill_drained", BLOCK_W'(drained - d0), BLOCK_W'(DEPTH));

      // Coalesce while another block drains
      applyStimulus(0, 1, 16'h0500, rnd_data(), 0, '0);
      idle(1);
      da = rnd_data();
      db = rnd_data();
      applyStimulus(0, 1, 16'h0040, da, 0, 16'h0040);
      applyStimulus(0, 1, 16'h0048, db, 0, 16'h0044);
      chk("coal_count", BLOCK_W'(count), BLOCK_W'(2));
      chk("coal_lookup", lookup_data, db);
      drain_all();

      // Push to the block whose write is in flight: fresh entry, snoop sees it
      applyStimulus(0, 1, 16'h0100, rnd_data(), 0, '0);
      idle(1);
      da = rnd_data();
      applyStimulus(0, 1, 16'h0100, da, 0, 16'h0104);
      applyStimulus(0, 0, '0, '0, 0, 16'h0104);
      chk("hid_lookup", lookup_data, da);
      chk("hid_count", BLOCK_W'(count), BLOCK_W'(2));
      drain_all();

      // Alternating push/drain, pointers wrap
      d0 = drained;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 1, ADDR_W'(16'h3000 + i * 16), rnd_data(), 0, '0);
         drain_all();
      end
      chk("wrap_drained", BLOCK_W'(drained - d0), BLOCK_W'(10));

      // Reset in the middle of a drain, late response ignored
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, ADDR_W'(16'h4000 + i * 16), rnd_data(), 0, '0);
      idle(1);
      applyStimulus(1, 0, '0, '0, 0, 16'h4000);
      d0 = drained;
      applyStimulus(0, 0, '0, '0, 1, 16'h4000);
      applyStimulus(0, 0, '0, '0, 1, 16'h4010);
      chk("reset_no_pop", BLOCK_W'(drained - d0), '0);
      chk("reset_count", BLOCK_W'(count), '0);

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1, rnd_addr(), rnd_data(),
                       $urandom_range(0, 2) == 0, rnd_addr());
      end
      drain_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
